// File: rtl/addsub_pipe_nbit_if.sv
// Operand/result stream for the pipelined adder/subtractor.
// The master drives operands and accepts results; the slave is the datapath.
interface addsub_pipe_nbit_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         add_n;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c_out;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, x, y, add_n, sat, out_ready,
    input  in_ready, out_valid, s, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, x, y, add_n, sat, out_ready,
    output in_ready, out_valid, s, c_out, ovf, zero
  );
endinterface

// File: rtl/addsub_pipe_nbit.sv
// Pipelined two's-complement adder/subtractor.
// Operands are captured in an input rank, then one CHUNK-bit ripple slice is
// resolved per stage. The untouched upper operand bits and the partial sum ride
// along in skew registers. The last slice feeds a reset output rank that holds
// the raw sum, carry and signed overflow. Saturation and zero are combinational
// off that rank. A stalled output freezes the whole pipe.
module addsub_pipe_nbit #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input logic               clk,
  input logic               rst,
  addsub_pipe_nbit_if.slave bus
);
  localparam int STAGES = N / CHUNK;
  localparam int L      = STAGES - 1;
  localparam logic signed [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  // Adds slice k of a and b plus cin, and merges it into the accumulated lower
  // result. Returns {carry out of the slice, updated sum}.
  function automatic logic [N:0] add_slice(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] acc, input logic cin,
                                           input int k);
    logic [CHUNK:0] t;
    t = {1'b0, CHUNK'(a >> (k * CHUNK))} + {1'b0, CHUNK'(b >> (k * CHUNK))}
      + {{CHUNK{1'b0}}, cin};
    return {t[CHUNK], acc | (N'(t[CHUNK-1:0]) << (k * CHUNK))};
  endfunction

  // A negative raw result on overflow means the true value went positive past max.
  function automatic logic signed [N-1:0] saturate(input logic signed [N-1:0] raw,
                                                   input logic ovf, input logic en);
    if (en && ovf) return raw[N-1] ? SMAX : SMIN;
    return raw;
  endfunction

  logic w_adv;

  // Per-slice sources (rank feeding slice k) and slice results.
  logic [N-1:0] w_x_src   [STAGES];
  logic [N-1:0] w_yi_src  [STAGES];
  logic [N-1:0] w_sum_src [STAGES];
  logic         w_c_src   [STAGES];
  logic         w_sat_src [STAGES];
  logic         w_vld_src [STAGES];
  logic [N-1:0] w_sum_nx  [STAGES];
  logic         w_c_nx    [STAGES];
  logic         w_ovf_nx;

  logic         r_vld_p0, r_cin_p0, r_sat_p0;
  logic [N-1:0] r_x_p0, r_yi_p0;

  logic                r_vld_o, r_c_o, r_ovf_o, r_sat_o;
  logic signed [N-1:0] r_raw_o;
  logic signed [N-1:0] w_s;

  // ---- input rank: operands captured, y pre-inverted for subtract ----
  // Valid bit of the input rank; cleared by reset, held during a stall.
  always_ff @(posedge clk) begin
    if (rst)        r_vld_p0 <= 1'b0;
    else if (w_adv) r_vld_p0 <= bus.in_valid;
  end

  // Operand capture; carry-in of slice 0 is add_n (two's-complement negate).
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_x_p0   <= bus.x;
      r_yi_p0  <= bus.y ^ {N{bus.add_n}};
      r_cin_p0 <= bus.add_n;
      r_sat_p0 <= bus.sat;
    end
  end

  assign w_x_src[0]   = r_x_p0;
  assign w_yi_src[0]  = r_yi_p0;
  assign w_sum_src[0] = '0;
  assign w_c_src[0]   = r_cin_p0;
  assign w_sat_src[0] = r_sat_p0;
  assign w_vld_src[0] = r_vld_p0;

  for (genvar k = 0; k < STAGES; k++) begin : g_add
    assign {w_c_nx[k], w_sum_nx[k]} =
      add_slice(w_x_src[k], w_yi_src[k], w_sum_src[k], w_c_src[k], k);
  end

  // ---- slice ranks 0..STAGES-2: partial sum plus skewed operands ----
  for (genvar k = 0; k < L; k++) begin : g_mid
    logic         r_vld_p, r_c_p, r_sat_p;
    logic [N-1:0] r_x_p, r_yi_p, r_sum_p;

    // Slice valid bit; bubbles travel as valid=0.
    always_ff @(posedge clk) begin
      if (rst)        r_vld_p <= 1'b0;
      else if (w_adv) r_vld_p <= w_vld_src[k];
    end

    // Slice data: chunk k resolved, everything else carried forward.
    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_x_p   <= w_x_src[k];
        r_yi_p  <= w_yi_src[k];
        r_sum_p <= w_sum_nx[k];
        r_c_p   <= w_c_nx[k];
        r_sat_p <= w_sat_src[k];
      end
    end

    assign w_x_src[k+1]   = r_x_p;
    assign w_yi_src[k+1]  = r_yi_p;
    assign w_sum_src[k+1] = r_sum_p;
    assign w_c_src[k+1]   = r_c_p;
    assign w_sat_src[k+1] = r_sat_p;
    assign w_vld_src[k+1] = r_vld_p;
  end

  // Carry into the MSB is recovered from the MSB's own sum bit.
  assign w_ovf_nx = (w_x_src[L][N-1] ^ w_yi_src[L][N-1] ^ w_sum_nx[L][N-1]) ^ w_c_nx[L];

  // ---- output rank: raw sum, carry, overflow; visible fields reset to zero ----
  // Output rank, loaded from the last slice whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_o <= 1'b0;
      r_raw_o <= '0;
      r_c_o   <= 1'b0;
      r_ovf_o <= 1'b0;
      r_sat_o <= 1'b0;
    end else if (w_adv) begin
      r_vld_o <= w_vld_src[L];
      r_raw_o <= w_sum_nx[L];
      r_c_o   <= w_c_nx[L];
      r_ovf_o <= w_ovf_nx;
      r_sat_o <= w_sat_src[L];
    end
  end

  assign w_adv         = !(r_vld_o && !bus.out_ready);
  assign w_s           = saturate(r_raw_o, r_ovf_o, r_sat_o);
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld_o;
  assign bus.s         = w_s;
  assign bus.c_out     = r_c_o;
  assign bus.ovf       = r_ovf_o;
  assign bus.zero      = r_vld_o && (w_s == '0);
endmodule

// File: doc/addsub_pipe_nbit.md
# addsub_pipe_nbit

Pipelined, parametrised two's-complement adder/subtractor. It adds or subtracts N-bit operands in N/CHUNK carry-chained stages, one CHUNK-bit ripple-carry slice per stage. It accepts one operation per cycle under a valid/ready handshake with backpressure, and reports carry/borrow, signed overflow and zero, with optional signed saturation. It is the streaming datapath successor to the 4-bit combinational adder/subtractor, used where wide operands would break timing as a single ripple chain.

## Interface
- N, default 16: operand/result width; must be an integer multiple of CHUNK, N ≥ CHUNK.
- CHUNK, default 4: bits resolved per pipeline stage; STAGES = N/CHUNK.
- clk  in  1  rising-edge clock; sole clock domain.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  in  1  operand set on x, y, add_n, sat is valid.
- in_ready  out  1  block can accept an operand set this cycle.
- x  in  N  minuend / first addend.
- y  in  N  subtrahend / second addend.
- add_n  in  1  0 = x+y, 1 = x−y (y inverted, carry-in 1).
- sat  in  1  1 = clamp signed overflow to signed max/min.
- out_valid  out  1  result fields valid.
- out_ready  in  1  downstream accepts the result this cycle.
- s  out  N  result (possibly saturated).
- c_out  out  1  carry out of the MSB. For subtract, 1 = no borrow (x ≥ y unsigned).
- ovf  out  1  signed overflow of the unsaturated result.
- zero  out  1  s == 0, evaluated after saturation.

## Operation
- Operand inversion: yi = y ^ {N{add_n}}. Carry into stage 0 = add_n.
- Stage k (0..STAGES−1):
  - Adds x[k·CHUNK +: CHUNK] + yi[k·CHUNK +: CHUNK] + carry_k.
  - Registers that chunk's sum and carry_(k+1).
  - Upper operand chunks, add_n-derived state and sat travel alongside in skew registers.
  - Lower result chunks travel forward in the same skew registers.
- Final stage registers the full raw sum, c_out = carry out of bit N−1, and ovf = carry into MSB ^ carry out of MSB.
- Saturation, combinational off the final registers:
  - If sat && ovf: s = raw MSB ? {0,{N−1{1}}} : {1,{N−1{0}}}. A negative raw result means positive overflow, so clamp to max; otherwise clamp to min.
  - Else s = raw sum.
  - ovf reports the raw overflow regardless of sat.
- zero = (s == 0).
- Each stage has a valid bit. The pipeline advances as a whole when adv = !(out_valid && !out_ready).
  - in_ready = adv (combinational).
  - No bubble collapsing is required: a stalled pipeline freezes entirely.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Any arithmetic width is exact: no truncation other than the modulo-2^N result.

## Timing
- Latency: an operand set accepted at edge t appears with out_valid=1 after edge t+STAGES, if no stall occurs. Default = 4 cycles.
- Throughput: one operation per cycle while out_ready=1.
- Stall: while out_valid && !out_ready:
  - s, c_out, ovf, zero and out_valid hold stable.
  - in_ready=0, and in_valid is ignored.
  - All stage registers hold.
- Simultaneous output accept and input accept in one cycle is legal and loses nothing.
- in_valid=0 inserts a bubble (stage valid=0). Bubbles propagate, and out_valid=0 when a bubble reaches the output.
- Reset (any cycle, including mid-stream or during a stall):
  - On the next edge, all stage valid bits = 0, out_valid=0, s=0, c_out=0, ovf=0, zero=0.
  - In-flight operations are discarded.
  - in_ready=1 in the first cycle after reset deasserts, provided out_valid=0.
- While rst=1, in_ready may assert, but no transfer is recorded.
- Data registers need not be reset, except the output fields listed above.
- Outputs are registered except s (saturation mux), zero and in_ready.

## Test plan
- Add, N=16/CHUNK=4: x=0x1234, y=0x0FFF, add_n=0, sat=0 → 4 cycles later s=0x2233, c_out=0, ovf=0, zero=0.
- Subtract with borrow: x=0x0005, y=0x0007, add_n=1 → s=0xFFFE, c_out=0, ovf=0. Then x=y=0xA5A5, add_n=1 → s=0x0000, c_out=1, zero=1.
- Overflow/saturation, signed:
  - x=0x7FFF, y=0x0001, add_n=0, sat=0 → s=0x8000, ovf=1.
  - Same operands with sat=1 → s=0x7FFF, ovf=1.
  - x=0x8000, y=0x0001, add_n=1, sat=1 → s=0x8000, ovf=1, c_out=1.
- Carry across every chunk boundary: x=0xFFFF, y=0x0001, add_n=0 → s=0x0000, c_out=1, zero=1, ovf=0.
- Throughput and backpressure:
  - Stream 20 random operand sets back-to-back, holding out_ready=0 for 3 cycles mid-stream.
  - Required: outputs in order, all match the reference model, nothing duplicated or lost, and in_ready=0 exactly during the stall cycles.
- Reset mid-flight: accept 3 operations, assert rst for 1 cycle → out_valid=0 for the following cycles, none of the 3 results emerge, and a new operation accepted after reset returns correctly after STAGES cycles. Repeat with N=8, CHUNK=8 (STAGES=1).
